// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Purpose  : Pipeline execute stage. Single-cycle ALU, branch resolution and a
//            16-step shift-add multiplier that stalls upstream while it runs.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int ISIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             mem_to_reg_in,
    input  logic             jal_in,
    input  logic             branch_in,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in1,
    input  logic [DSIZE-1:0] rdata2_in2,
    input  logic [DSIZE-1:0] imm_in,
    input  logic [3:0]       opcode_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [ISIZE-1:0] nPC_in,
    output logic             stall_out,
    output logic             branch_taken_out,
    output logic [ISIZE-1:0] branch_target_out,
    output logic             wen_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             mem_to_reg_out,
    output logic [DSIZE-1:0] alu_out,
    output logic [DSIZE-1:0] wdata_out,
    output logic [ASIZE-1:0] waddr_out
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_SLL = 4'd5;
    localparam logic [3:0] c_OP_SRL = 4'd6;
    localparam logic [3:0] c_OP_SRA = 4'd7;
    localparam logic [3:0] c_OP_LW  = 4'd8;
    localparam logic [3:0] c_OP_SW  = 4'd9;
    localparam logic [3:0] c_OP_MUL = 4'd10;
    localparam logic [3:0] c_OP_LHB = 4'd11;
    localparam logic [3:0] c_OP_BEQ = 4'd12;
    localparam logic [3:0] c_LAST_STEP = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    mul_state_t       r_state;
    mul_state_t       w_state_next;

    logic [DSIZE-1:0] r_mcand;
    logic [DSIZE-1:0] r_mplier;
    logic [DSIZE-1:0] r_prod;
    logic [3:0]       r_count;

    // Controls and store data of the multiply, retired in DONE.
    logic             r_h_wen;
    logic             r_h_mem_read;
    logic             r_h_mem_write;
    logic             r_h_mem_to_reg;
    logic [DSIZE-1:0] r_h_wdata;
    logic [ASIZE-1:0] r_h_waddr;

    logic             w_mul_start;
    logic [3:0]       w_shamt;
    logic [DSIZE-1:0] w_sra;
    logic [DSIZE-1:0] w_alu_result;

    assign w_mul_start = (r_state == S_IDLE) && (opcode_in == c_OP_MUL);
    assign stall_out   = w_mul_start || (r_state == S_RUN);

    assign branch_taken_out  = branch_in && (rdata1_in == rdata2_in1) && !stall_out;
    assign branch_target_out = nPC_in + imm_in[ISIZE-1:0];

    assign w_shamt = rdata2_in1[3:0];
    assign w_sra   = $signed(rdata1_in) >>> w_shamt;

    always_comb begin
        w_alu_result = '0;
        case (opcode_in)
            c_OP_ADD: w_alu_result = rdata1_in + rdata2_in1;
            c_OP_SUB: w_alu_result = rdata1_in - rdata2_in1;
            c_OP_AND: w_alu_result = rdata1_in & rdata2_in1;
            c_OP_OR:  w_alu_result = rdata1_in | rdata2_in1;
            c_OP_XOR: w_alu_result = rdata1_in ^ rdata2_in1;
            c_OP_SLL: w_alu_result = rdata1_in << w_shamt;
            c_OP_SRL: w_alu_result = rdata1_in >> w_shamt;
            c_OP_SRA: w_alu_result = w_sra;
            c_OP_LW:  w_alu_result = rdata1_in + rdata2_in1;
            c_OP_SW:  w_alu_result = rdata1_in + rdata2_in1;
            c_OP_LHB: w_alu_result = {rdata2_in1[7:0], rdata1_in[7:0]};
            c_OP_BEQ: w_alu_result = rdata1_in - rdata2_in1;
            default:  w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (opcode_in == c_OP_MUL) w_state_next = S_RUN;
            S_RUN:   if (r_count == c_LAST_STEP) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_prod         <= '0;
            r_count        <= '0;
            r_h_wen        <= 1'b0;
            r_h_mem_read   <= 1'b0;
            r_h_mem_write  <= 1'b0;
            r_h_mem_to_reg <= 1'b0;
            r_h_wdata      <= '0;
            r_h_waddr      <= '0;
        end else if (w_mul_start) begin
            r_mcand        <= rdata1_in;
            r_mplier       <= rdata2_in1;
            r_prod         <= '0;
            r_count        <= '0;
            r_h_wen        <= wen_in;
            r_h_mem_read   <= mem_read_in;
            r_h_mem_write  <= mem_write_in;
            r_h_mem_to_reg <= mem_to_reg_in;
            r_h_wdata      <= rdata2_in2;
            r_h_waddr      <= waddr_in;
        end else if (r_state == S_RUN) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 4'd1;
        end
    end

    // EXE/MEM register: bubble while stalled, multiply result in DONE.
    always_ff @(posedge clk) begin
        if (rst || stall_out) begin
            wen_out        <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            alu_out        <= '0;
            wdata_out      <= '0;
            waddr_out      <= '0;
        end else if (r_state == S_DONE) begin
            wen_out        <= r_h_wen;
            mem_read_out   <= r_h_mem_read;
            mem_write_out  <= r_h_mem_write;
            mem_to_reg_out <= r_h_mem_to_reg;
            alu_out        <= r_prod;
            wdata_out      <= r_h_wdata;
            waddr_out      <= r_h_waddr;
        end else begin
            wen_out        <= wen_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            mem_to_reg_out <= mem_to_reg_in;
            alu_out        <= jal_in ? DSIZE'(nPC_in) : w_alu_result;
            wdata_out      <= rdata2_in2;
            waddr_out      <= waddr_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage
// Purpose  : Self-checking bench for exe_stage: directed vectors, multiply and
//            reset corner sequences, and randomized ops against a reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen_in, mem_read_in, mem_write_in, mem_to_reg_in, jal_in, branch_in;
    logic [15:0] rdata1_in, rdata2_in1, rdata2_in2, imm_in;
    logic [3:0]  opcode_in;
    logic [3:0]  waddr_in;
    logic [15:0] nPC_in;
    logic        stall_out, branch_taken_out;
    logic [15:0] branch_target_out;
    logic        wen_out, mem_read_out, mem_write_out, mem_to_reg_out;
    logic [15:0] alu_out, wdata_out;
    logic [3:0]  waddr_out;

    int total = 0;
    int bad   = 0;

    exe_stage #(.DSIZE(16), .ASIZE(4), .ISIZE(16)) dut (
        .clk(clk), .rst(rst),
        .wen_in(wen_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .jal_in(jal_in), .branch_in(branch_in),
        .rdata1_in(rdata1_in), .rdata2_in1(rdata2_in1), .rdata2_in2(rdata2_in2),
        .imm_in(imm_in), .opcode_in(opcode_in), .waddr_in(waddr_in), .nPC_in(nPC_in),
        .stall_out(stall_out), .branch_taken_out(branch_taken_out),
        .branch_target_out(branch_target_out),
        .wen_out(wen_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .mem_to_reg_out(mem_to_reg_out), .alu_out(alu_out), .wdata_out(wdata_out),
        .waddr_out(waddr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference ALU written directly from the opcode table.
    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic jal,
                                            input logic [15:0] npc);
        int unsigned sh;
        logic signed [15:0] sa;
        logic [15:0] r;
        sh = int'(b[3:0]);
        sa = a;
        if (jal) return npc;
        case (op)
            4'd0, 4'd8, 4'd9: r = a + b;
            4'd1, 4'd12:      r = a - b;
            4'd2:             r = a & b;
            4'd3:             r = a | b;
            4'd4:             r = a ^ b;
            4'd5:             r = a << sh;
            4'd6:             r = a >> sh;
            4'd7:             r = sa >>> sh;
            4'd11:            r = {b[7:0], a[7:0]};
            default:          r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic set_nop();
        wen_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
        jal_in = 0; branch_in = 0;
        rdata1_in = 0; rdata2_in1 = 0; rdata2_in2 = 0; imm_in = 0;
        opcode_in = 4'd13; waddr_in = 0; nPC_in = 0;
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_alu"}, alu_out, 0);
        chk({name, "_wdata"}, wdata_out, 0);
        chk({name, "_waddr"}, waddr_out, 0);
        chk({name, "_ctl"}, {wen_out, mem_read_out, mem_write_out, mem_to_reg_out}, 0);
    endtask

    // Presents a MUL and follows it through stall, bubbles and retirement.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [3:0] wa);
        int n;
        logic [15:0] sd;
        logic [31:0] full;
        sd = 16'($urandom);
        @(negedge clk);
        set_nop();
        opcode_in = 4'd10; rdata1_in = a; rdata2_in1 = b; rdata2_in2 = sd;
        wen_in = 1; waddr_in = wa; branch_in = 1;
        #1;
        chk("mul_stall_start", stall_out, 1);
        chk("mul_no_branch", branch_taken_out, 0);
        n = 0;
        while (stall_out && n < 40) begin
            @(posedge clk); #1;
            n++;
            chk_zero_outputs("mul_bubble");
        end
        chk("mul_stall_len", n, 17);
        chk("mul_done_stall", stall_out, 0);
        @(posedge clk); #1;
        full = a * b;
        chk("mul_product", alu_out, full[15:0]);
        chk("mul_wen", wen_out, 1);
        chk("mul_waddr", waddr_out, wa);
        chk("mul_wdata", wdata_out, sd);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        jal;
        logic [15:0] npc;
        logic [3:0]  wa;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        set_nop();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        chk("reset_stall", stall_out, 0);
        @(negedge clk);
        rst = 0;

        tbl[0] = '{4'd0,  16'hFFFF, 16'h0002, 1'b0, 16'h0000, 4'd3,  16'h0001};
        tbl[1] = '{4'd7,  16'h8000, 16'h0004, 1'b0, 16'h0000, 4'd1,  16'hF800};
        tbl[2] = '{4'd6,  16'h8000, 16'h0004, 1'b0, 16'h0000, 4'd2,  16'h0800};
        tbl[3] = '{4'd0,  16'h0005, 16'h0006, 1'b1, 16'h0042, 4'd15, 16'h0042};
        tbl[4] = '{4'd11, 16'h12AB, 16'h34CD, 1'b0, 16'h0000, 4'd4,  16'hCDAB};
        tbl[5] = '{4'd1,  16'h0000, 16'h0001, 1'b0, 16'h0000, 4'd5,  16'hFFFF};
        tbl[6] = '{4'd5,  16'h0001, 16'h0013, 1'b0, 16'h0000, 4'd6,  16'h0008};
        tbl[7] = '{4'd14, 16'h1234, 16'h5678, 1'b0, 16'h0000, 4'd7,  16'h0000};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_nop();
            opcode_in = tbl[i].op; rdata1_in = tbl[i].a; rdata2_in1 = tbl[i].b;
            jal_in = tbl[i].jal; nPC_in = tbl[i].npc; waddr_in = tbl[i].wa;
            rdata2_in2 = tbl[i].a ^ tbl[i].b; wen_in = 1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_alu", i), alu_out, tbl[i].exp);
            chk($sformatf("vec%0d_waddr", i), waddr_out, tbl[i].wa);
            chk($sformatf("vec%0d_wen", i), wen_out, 1);
            chk($sformatf("vec%0d_wdata", i), wdata_out, tbl[i].a ^ tbl[i].b);
        end

        @(negedge clk);
        set_nop();
        opcode_in = 4'd12; branch_in = 1; rdata1_in = 16'h1234; rdata2_in1 = 16'h1234;
        nPC_in = 16'h0010; imm_in = 16'hFFFE;
        #1;
        chk("beq_taken", branch_taken_out, 1);
        chk("beq_target", branch_target_out, 16'h000E);
        rdata2_in1 = 16'h1235;
        #1;
        chk("beq_not_taken", branch_taken_out, 0);

        run_mul(16'h0123, 16'h0045, 4'd9);
        run_mul(16'hFFFF, 16'hFFFF, 4'd2);

        // Reset in the middle of a multiply.
        @(negedge clk);
        set_nop();
        opcode_in = 4'd10; rdata1_in = 16'h00FF; rdata2_in1 = 16'h0101; wen_in = 1; waddr_in = 7;
        repeat (9) @(posedge clk);
        @(negedge clk);
        set_nop();
        rst = 1;
        @(posedge clk); #1;
        chk_zero_outputs("midrst");
        chk("midrst_stall", stall_out, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("postrst_stall", stall_out, 0);
        run_mul(16'h00FF, 16'h0101, 4'd7);

        for (int k = 0; k < 200; k++) begin
            logic [3:0]  op, wa;
            logic [15:0] a, b, sd, imm, npc;
            logic        jal, br, w, mr, mw, m2r;
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom); b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            if (op == 4'd10) begin
                run_mul(a, b, 4'($urandom));
            end else begin
                sd = 16'($urandom); imm = 16'($urandom); npc = 16'($urandom);
                wa = 4'($urandom); jal = 1'($urandom); br = 1'($urandom);
                w = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom); m2r = 1'($urandom);
                @(negedge clk);
                opcode_in = op; rdata1_in = a; rdata2_in1 = b; rdata2_in2 = sd;
                imm_in = imm; nPC_in = npc; waddr_in = wa; jal_in = jal; branch_in = br;
                wen_in = w; mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = m2r;
                #1;
                chk("rnd_stall", stall_out, 0);
                chk("rnd_taken", branch_taken_out, br && (a == b));
                chk("rnd_target", branch_target_out, 16'(npc + imm));
                @(posedge clk); #1;
                chk("rnd_alu", alu_out, ref_alu(op, a, b, jal, npc));
                chk("rnd_wdata", wdata_out, sd);
                chk("rnd_waddr", waddr_out, wa);
                chk("rnd_ctl", {wen_out, mem_read_out, mem_write_out, mem_to_reg_out},
                    {w, mr, mw, m2r});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Widths SHALL come from the project define file: DSIZE = data width (16), ASIZE = register address width (4), ISIZE = instruction/PC width (16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 wen_in, mem_read_in, mem_write_in, mem_to_reg_in, jal_in, branch_in  in  1 each  control bits from the ID/EXE register.
REQ-005 rdata1_in  in  DSIZE  ALU operand A; rdata2_in1  in  DSIZE  ALU operand B (register or immediate, already selected); rdata2_in2  in  DSIZE  store data.
REQ-006 imm_in  in  DSIZE  branch offset; opcode_in  in  4  operation; waddr_in  in  ASIZE  destination register; nPC_in  in  ISIZE  PC+1 of the instruction.
REQ-007 stall_out  out  1  freezes PC, IF/ID and ID/EXE while a multiply runs (combinational).
REQ-008 branch_taken_out  out  1, branch_target_out  out  ISIZE  branch resolution (combinational).
REQ-009 wen_out, mem_read_out, mem_write_out, mem_to_reg_out  out  1 each; alu_out  out  DSIZE; wdata_out  out  DSIZE; waddr_out  out  ASIZE -- registered EXE/MEM outputs.

Function
REQ-010 Opcode map SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LW (A+B), 9 SW (A+B), 10 MUL, 11 LHB ({B[7:0],A[7:0]}), 12 BEQ (A-B), 13-15 result 0.
REQ-011 Arithmetic SHALL be modulo 2^DSIZE; no overflow flag; shift amount = B[3:0]; SRA replicates A[15].
REQ-012 jal_in=1 SHALL force alu_out source to nPC_in regardless of opcode.
REQ-013 Non-MUL ops: single-cycle; on each non-stalled edge the EXE/MEM outputs SHALL load result, rdata2_in2, waddr_in and the four control bits (latency 1).
REQ-014 branch_taken_out SHALL = branch_in AND (rdata1_in == rdata2_in1) AND NOT stall_out; branch_target_out = nPC_in + imm_in[ISIZE-1:0], wrapping.
REQ-015 MUL FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE with opcode_in=10: load multiplicand=A, multiplier=B, product=0, count=0; go RUN.
REQ-017 RUN: one shift-add step per cycle (if multiplier[0] add multiplicand to product; multiplicand<<=1; multiplier>>=1; count++); after 16th step go DONE.
REQ-018 DONE: alu_out SHALL load product[15:0] with the held instruction's controls; go IDLE.
REQ-019 stall_out SHALL = (IDLE AND opcode_in=10) OR RUN; high exactly 17 consecutive cycles per MUL; low in DONE.
REQ-020 While stall_out=1, EXE/MEM outputs SHALL load a bubble: wen/mem_read/mem_write/mem_to_reg = 0, alu_out, wdata_out, waddr_out = 0.
REQ-021 Upstream holds inputs constant while stall_out=1; block SHALL use its latched operands, not live inputs, during RUN.
REQ-022 Back-to-back MULs: DONE returns to IDLE, next MUL starts the following cycle; no cycle lost beyond REQ-019.
REQ-023 MUL with jal_in=1 is illegal upstream; behaviour unspecified.

Reset
REQ-024 rst=1 SHALL have priority over all activity, including mid-multiply: FSM -> IDLE, count/product cleared, all registered outputs 0.
REQ-025 stall_out SHALL be 0 in the cycle after reset unless opcode_in=10 is presented.
REQ-026 Reset state SHALL be identical whether or not a multiply was in progress.

Verification
REQ-027 ADD A=0xFFFF B=0x0002 wen_in=1 waddr_in=3 -> next edge alu_out=0x0001, wen_out=1, waddr_out=3.
REQ-028 SRA A=0x8000 B=0x0004 -> alu_out=0xF800; SRL same operands -> 0x0800.
REQ-029 BEQ branch_in=1 A=B=0x1234 nPC_in=0x0010 imm_in=0xFFFE -> branch_taken_out=1, branch_target_out=0x000E same cycle; A!=B -> 0.
REQ-030 MUL A=0x0123 B=0x0045 wen_in=1 -> stall_out high 17 cycles, bubbles on outputs, then alu_out=0x4E6F, wen_out=1.
REQ-031 rst asserted at RUN step 8 -> next edge all outputs 0, stall_out=0; fresh MUL afterwards gives correct product.
REQ-032 jal_in=1 nPC_in=0x0042 wen_in=1 waddr_in=15 -> alu_out=0x0042, waddr_out=15.
